// File: rtl/player_ctrl.sv
// Per-frame player kinematics: walk, gravity, double jump, floor/ceiling/edge clamp.
// Tick to new outputs in 3 cycles; ticks while an update is in flight are ignored.
module player_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int PLAYER_W  = 16,
  parameter int PLAYER_H  = 16,
  parameter int FLOOR_Y   = 448,
  parameter int START_X   = 32,
  parameter int WALK_SPD  = 2,
  parameter int JUMP_V    = 8,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 8,
  parameter int MAX_JUMPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing,
  output logic       on_ground,
  output logic       update_done
);

  localparam int JW     = $clog2(MAX_JUMPS + 1);
  localparam int REST_Y = FLOOR_Y - PLAYER_H;
  localparam int MAX_X  = SCREEN_W - PLAYER_W;

  localparam logic [JW-1:0]     JUMPS_FULL = JW'(MAX_JUMPS);
  localparam logic [JW-1:0]     JUMP_ONE   = JW'(1);
  localparam logic signed [5:0] VY_JUMP    = 6'(-JUMP_V);
  localparam logic signed [5:0] VY_GRAV    = 6'(GRAVITY);
  localparam logic signed [6:0] VY_MAXF7   = 7'(MAX_FALL);
  localparam logic [10:0]       WALK11     = 11'(WALK_SPD);
  localparam logic [10:0]       MAXX11     = 11'(MAX_X);
  localparam logic signed [10:0] RESTY11   = 11'(REST_Y);

  typedef enum logic [1:0] {GROUND, RISE, FALL} mstate_e;
  typedef enum logic [1:0] {P_IDLE, P_S1, P_S2} phase_e;

  phase_e            phase_q;
  mstate_e           state_q;
  logic signed [5:0] vy_q;
  logic [JW-1:0]     jumps_left_q;
  logic              jump_pend_q, rel_pend_q, btn_jump_q;
  logic [9:0]        x_wk_q;
  logic              face_wk_q;
  logic [9:0]        pos_x_q, pos_y_q;
  logic              facing_q, on_ground_q, update_done_q;

  logic jump_rise, jump_fall;
  assign jump_rise = btn_jump & ~btn_jump_q;
  assign jump_fall = ~btn_jump & btn_jump_q;

  // Horizontal step, used in S1.
  logic [9:0]  x_d;
  logic        face_d;
  logic [10:0] x_ext, x_sum;
  always_comb begin
    x_d    = pos_x_q;
    face_d = facing_q;
    x_ext  = {1'b0, pos_x_q};
    x_sum  = x_ext + WALK11;
    if (btn_left ^ btn_right) begin
      if (btn_left) begin
        face_d = 1'b0;
        if (x_ext < WALK11) x_d = '0;
        else                x_d = pos_x_q - WALK11[9:0];
      end else begin
        face_d = 1'b1;
        if (x_sum > MAXX11) x_d = MAXX11[9:0];
        else                x_d = x_sum[9:0];
      end
    end
  end

  // Velocity step, used in S1. vy stays within +-JUMP_V so negation is safe.
  logic signed [5:0] vy_d, vy_cut;
  logic signed [6:0] vy_inc;
  logic [5:0]        vy_mag, vy_half;
  mstate_e           st1_d;
  logic [JW-1:0]     jl1_d;
  always_comb begin
    vy_d    = vy_q;
    st1_d   = state_q;
    jl1_d   = jumps_left_q;
    vy_mag  = 6'(-vy_q);
    vy_half = vy_mag >> 1;
    vy_cut  = -$signed(vy_half) + VY_GRAV;
    vy_inc  = {vy_q[5], vy_q} + {VY_GRAV[5], VY_GRAV};
    if (jump_pend_q && jumps_left_q != '0) begin
      vy_d  = VY_JUMP;
      jl1_d = jumps_left_q - JUMP_ONE;
      st1_d = RISE;
    end else if (rel_pend_q && vy_q[5]) begin
      vy_d = vy_cut;
    end else if (state_q != GROUND) begin
      if (vy_inc > VY_MAXF7) vy_d = VY_MAXF7[5:0];
      else                   vy_d = vy_inc[5:0];
    end
  end

  // Vertical step, used in S2.
  logic signed [10:0] ny;
  logic [9:0]         y_d;
  logic signed [5:0]  vy2_d;
  mstate_e            st2_d;
  logic [JW-1:0]      jl2_d;
  always_comb begin
    ny    = $signed({1'b0, pos_y_q}) + $signed({{5{vy_q[5]}}, vy_q});
    y_d   = ny[9:0];
    vy2_d = vy_q;
    jl2_d = jumps_left_q;
    st2_d = vy_q[5] ? RISE : FALL;
    if (ny >= RESTY11) begin
      y_d   = RESTY11[9:0];
      vy2_d = '0;
      st2_d = GROUND;
      jl2_d = JUMPS_FULL;
    end else if (ny[10]) begin
      y_d   = '0;
      vy2_d = '0;
      st2_d = FALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= P_IDLE;
      state_q       <= GROUND;
      vy_q          <= '0;
      jumps_left_q  <= JUMPS_FULL;
      jump_pend_q   <= 1'b0;
      rel_pend_q    <= 1'b0;
      btn_jump_q    <= 1'b0;
      x_wk_q        <= 10'(START_X);
      face_wk_q     <= 1'b1;
      pos_x_q       <= 10'(START_X);
      pos_y_q       <= RESTY11[9:0];
      facing_q      <= 1'b1;
      on_ground_q   <= 1'b1;
      update_done_q <= 1'b0;
    end else begin
      btn_jump_q    <= btn_jump;
      update_done_q <= 1'b0;
      jump_pend_q   <= jump_pend_q | jump_rise;
      rel_pend_q    <= rel_pend_q  | jump_fall;
      case (phase_q)
        P_IDLE: if (frame_tick) phase_q <= P_S1;
        P_S1: begin
          x_wk_q       <= x_d;
          face_wk_q    <= face_d;
          vy_q         <= vy_d;
          state_q      <= st1_d;
          jumps_left_q <= jl1_d;
          // Pending edges are consumed; an edge arriving this very cycle survives.
          jump_pend_q  <= jump_rise;
          rel_pend_q   <= jump_fall;
          phase_q      <= P_S2;
        end
        P_S2: begin
          pos_x_q       <= x_wk_q;
          facing_q      <= face_wk_q;
          pos_y_q       <= y_d;
          vy_q          <= vy2_d;
          state_q       <= st2_d;
          jumps_left_q  <= jl2_d;
          on_ground_q   <= (st2_d == GROUND);
          update_done_q <= 1'b1;
          phase_q       <= P_IDLE;
        end
        default: phase_q <= P_IDLE;
      endcase
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign facing      = facing_q;
  assign on_ground   = on_ground_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: walk/clamp, jump arcs, jump cut, air jump, reset abort.
module tb_player_ctrl;
  logic       clk = 1'b0;
  logic       rst, frame_tick, btn_left, btn_right, btn_jump;
  logic [9:0] pos_x, pos_y;
  logic       facing, on_ground, update_done;

  int checks = 0;
  int failures = 0;

  player_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing),
    .on_ground(on_ground), .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse frame_tick for one cycle and wait (bounded) for update_done.
  task automatic do_tick();
    int lat;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    lat = 1;
    while (!update_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("tick_latency", lat, 3);
  endtask

  task automatic land(input string tag);
    for (int i = 0; i < 40 && !on_ground; i++) do_tick();
    chk({tag, "_on_ground"}, int'(on_ground), 1);
    chk({tag, "_y"}, int'(pos_y), 432);
  endtask

  int traj[17] = '{424, 417, 411, 406, 402, 399, 397, 396, 396,
                   397, 399, 402, 406, 411, 417, 424, 432};
  int pulses;

  initial begin
    rst = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and an idle tick
    chk("rst_x", int'(pos_x), 32);
    chk("rst_y", int'(pos_y), 432);
    chk("rst_ground", int'(on_ground), 1);
    chk("rst_facing", int'(facing), 1);
    chk("rst_done", int'(update_done), 0);
    do_tick();
    chk("idle_x", int'(pos_x), 32);
    chk("idle_y", int'(pos_y), 432);
    @(posedge clk); #1;
    chk("done_single_cycle", int'(update_done), 0);

    // Walk right, then clamp at the left edge
    btn_right = 1'b1;
    repeat (10) do_tick();
    chk("walk_right_x", int'(pos_x), 52);
    chk("walk_right_facing", int'(facing), 1);
    btn_right = 1'b0; btn_left = 1'b1;
    repeat (25) do_tick();
    chk("walk_left_x", int'(pos_x), 2);
    chk("walk_left_facing", int'(facing), 0);
    do_tick();
    chk("clamp_left_x0", int'(pos_x), 0);
    do_tick();
    chk("clamp_left_hold", int'(pos_x), 0);
    btn_left = 1'b1; btn_right = 1'b1;
    do_tick();
    chk("both_x", int'(pos_x), 0);
    chk("both_facing", int'(facing), 0);
    btn_left = 1'b0; btn_right = 1'b0;

    // Full jump arc with button held
    btn_jump = 1'b1;
    for (int i = 0; i < 17; i++) begin
      do_tick();
      chk($sformatf("arc_y%0d", i), int'(pos_y), traj[i]);
      if (i == 15) chk("arc_air", int'(on_ground), 0);
    end
    chk("arc_landed", int'(on_ground), 1);
    chk("arc_jumps_left", int'(dut.jumps_left_q), 2);
    btn_jump = 1'b0;
    do_tick();
    chk("release_on_ground_y", int'(pos_y), 432);

    // Jump cut
    btn_jump = 1'b1;
    do_tick();
    chk("cut_y0", int'(pos_y), 424);
    btn_jump = 1'b0;
    do_tick();
    chk("cut_y1", int'(pos_y), 421);
    land("cut_land");

    // Double jump, third press dropped
    btn_jump = 1'b1;
    do_tick();
    chk("dj_y1", int'(pos_y), 424);
    btn_jump = 1'b0;
    @(posedge clk); #1 btn_jump = 1'b1;
    do_tick();
    chk("dj_y2", int'(pos_y), 416);
    repeat (8) do_tick();
    chk("dj_apex_y", int'(pos_y), 388);
    btn_jump = 1'b0;
    do_tick();
    chk("dj_fall_y", int'(pos_y), 389);
    btn_jump = 1'b1;
    do_tick();
    chk("dj_third_ignored_y", int'(pos_y), 391);
    chk("dj_third_air", int'(on_ground), 0);
    btn_jump = 1'b0;
    land("dj_land");
    chk("dj_jumps_refill", int'(dut.jumps_left_q), 2);

    // Ticks during an update are ignored
    btn_right = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b0;
    pulses = int'(update_done);
    repeat (8) begin
      @(posedge clk); #1;
      pulses += int'(update_done);
    end
    chk("busy_tick_pulses", pulses, 1);
    chk("busy_tick_x", int'(pos_x), 2);

    // Reset during S1 aborts the update; jump held through reset fires
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    rst = 1'b1; btn_jump = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    btn_right = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      pulses += int'(update_done);
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_x", int'(pos_x), 32);
    chk("abort_y", int'(pos_y), 432);
    chk("abort_ground", int'(on_ground), 1);
    do_tick();
    chk("held_jump_y", int'(pos_y), 424);
    chk("held_jump_air", int'(on_ground), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
